// File: rtl/stump_ctrl_pkg.sv
// Shared encodings for the STUMP control unit: FSM states, opcodes,
// branch condition codes and condition-flag bit positions.
package stump_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH   = 3'b001,
      S_EXECUTE = 3'b010,
      S_MEMORY  = 3'b100
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADC  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_SBC  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_LDST = 3'b110;
   localparam logic [2:0] OP_BCC  = 3'b111;

   typedef enum logic [3:0] {
      C_AL = 4'h0, C_NV = 4'h1, C_HI = 4'h2, C_LS = 4'h3,
      C_CC = 4'h4, C_CS = 4'h5, C_NE = 4'h6, C_EQ = 4'h7,
      C_VC = 4'h8, C_VS = 4'h9, C_PL = 4'hA, C_MI = 4'hB,
      C_GE = 4'hC, C_LT = 4'hD, C_GT = 4'hE, C_LE = 4'hF
   } cond_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

endpackage

// File: rtl/stump_cond_eval.sv
// Branch condition evaluator: decides whether a Bcc is taken from the
// 4-bit condition field and the {N,Z,V,C} flags.
module stump_cond_eval
   import stump_ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       taken
);

   logic n, z, v, c;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign v = flags[FLAG_V];
   assign c = flags[FLAG_C];

   always_comb begin
      taken = 1'b0;
      case (cond_t'(cond))
         C_AL: taken = 1'b1;
         C_NV: taken = 1'b0;
         C_HI: taken = !c && !z;
         C_LS: taken = c || z;
         C_CC: taken = !c;
         C_CS: taken = c;
         C_NE: taken = !z;
         C_EQ: taken = z;
         C_VC: taken = !v;
         C_VS: taken = v;
         C_PL: taken = !n;
         C_MI: taken = n;
         C_GE: taken = (n == v);
         C_LT: taken = (n != v);
         C_GT: taken = !z && (n == v);
         C_LE: taken = z || (n != v);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/stump_controller.sv
// STUMP control unit: one-hot FETCH/EXECUTE/MEMORY sequencer with
// combinational datapath control decode. Define STUMP_MEM_WAIT_EN to add
// the mem_ready handshake that stretches FETCH and MEMORY.
module stump_controller
   import stump_ctrl_pkg::*;
#(
   parameter logic [2:0] PC_REG = 3'd7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir,
   input  logic [3:0]  flags,
`ifdef STUMP_MEM_WAIT_EN
   input  logic        mem_ready,
`endif
   output logic [2:0]  state,
   output logic        fetch_en,
   output logic        reg_write,
   output logic        cc_en,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [2:0]  alu_func,
   output logic [1:0]  shift_op,
   output logic [2:0]  dest,
   output logic [2:0]  src_a,
   output logic [2:0]  src_b,
   output logic        ext_op,
   output logic        imm_type,
   output logic        addr_sel
);

   state_t     cur, nxt;
   logic       ready;
   logic       taken;
   logic [2:0] opcode;

`ifdef STUMP_MEM_WAIT_EN
   assign ready = mem_ready;
`else
   assign ready = 1'b1;
`endif

   assign opcode = ir[15:13];
   assign state  = cur;

   stump_cond_eval u_cond (
      .cond  (ir[11:8]),
      .flags (flags),
      .taken (taken)
   );

   always_ff @(posedge clk) begin
      if (rst) cur <= S_FETCH;
      else     cur <= nxt;
   end

   always_comb begin
      nxt       = cur;
      fetch_en  = 1'b0;
      reg_write = 1'b0;
      cc_en     = 1'b0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      alu_func  = 3'b000;
      shift_op  = 2'b00;
      dest      = 3'b000;
      src_a     = 3'b000;
      src_b     = 3'b000;
      ext_op    = 1'b0;
      imm_type  = 1'b0;
      addr_sel  = 1'b0;

      unique case (cur)
         S_FETCH: begin
            if (ready) nxt = S_EXECUTE;
            fetch_en = 1'b1;
            mem_ren  = 1'b1;
         end
         S_EXECUTE: begin
            if (opcode == OP_LDST) nxt = S_MEMORY;
            else                   nxt = S_FETCH;
            if (opcode == OP_BCC) begin
               src_a     = PC_REG;
               dest      = PC_REG;
               ext_op    = 1'b1;
               imm_type  = 1'b1;
               reg_write = taken;
            end else if (opcode == OP_LDST) begin
               // address = src_a + (reg or imm); ALU forced to ADD
               alu_func = OP_ADD;
               ext_op   = ir[12];
               src_a    = ir[7:5];
               src_b    = ir[4:2];
            end else begin
               alu_func  = opcode;
               ext_op    = ir[12];
               dest      = ir[10:8];
               src_a     = ir[7:5];
               src_b     = ir[4:2];
               shift_op  = ir[12] ? 2'b00 : ir[1:0];
               reg_write = 1'b1;
               cc_en     = ir[11];
            end
         end
         S_MEMORY: begin
            if (ready) nxt = S_FETCH;
            addr_sel = 1'b1;
            dest     = ir[10:8];
            if (ir[11]) begin
               mem_wen = 1'b1;
            end else begin
               mem_ren   = 1'b1;
               reg_write = 1'b1;
            end
         end
         default: nxt = S_FETCH;
      endcase

      // reset silences every control output; only the state register shows
      if (rst) begin
         fetch_en  = 1'b0;
         reg_write = 1'b0;
         cc_en     = 1'b0;
         mem_ren   = 1'b0;
         mem_wen   = 1'b0;
         alu_func  = 3'b000;
         shift_op  = 2'b00;
         dest      = 3'b000;
         src_a     = 3'b000;
         src_b     = 3'b000;
         ext_op    = 1'b0;
         imm_type  = 1'b0;
         addr_sel  = 1'b0;
      end
   end

endmodule

// File: tb/tb_stump_controller.sv
// Self-checking bench for stump_controller: directed instruction sequences
// followed by random instructions/flags/resets against a phase-level model.
module tb_stump_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] ir = 16'h0;
   logic [3:0]  flags = 4'h0;
   logic        mem_ready = 1'b1;

   logic [2:0]  state;
   logic        fetch_en, reg_write, cc_en, mem_ren, mem_wen;
   logic [2:0]  alu_func;
   logic [1:0]  shift_op;
   logic [2:0]  dest, src_a, src_b;
   logic        ext_op, imm_type, addr_sel;

   int checks = 0;
   int failures = 0;
   int ph = 0;  // 0 = fetch, 1 = execute, 2 = memory

   typedef struct packed {
      logic [2:0] st;
      logic       fe, rw, cc, mr, mw;
      logic [2:0] af;
      logic [1:0] so;
      logic [2:0] d, a, b;
      logic       eo, it, as;
   } exp_t;

   always #5 clk = ~clk;

   stump_controller #(.PC_REG(3'd7)) dut (
      .clk       (clk),
      .rst       (rst),
      .ir        (ir),
      .flags     (flags),
`ifdef STUMP_MEM_WAIT_EN
      .mem_ready (mem_ready),
`endif
      .state     (state),
      .fetch_en  (fetch_en),
      .reg_write (reg_write),
      .cc_en     (cc_en),
      .mem_ren   (mem_ren),
      .mem_wen   (mem_wen),
      .alu_func  (alu_func),
      .shift_op  (shift_op),
      .dest      (dest),
      .src_a     (src_a),
      .src_b     (src_b),
      .ext_op    (ext_op),
      .imm_type  (imm_type),
      .addr_sel  (addr_sel)
   );

   // Conditions come in complementary pairs: odd codes invert the even one.
   function automatic logic cond_taken(logic [3:0] c, logic [3:0] f);
      logic n, z, v, cy, base;
      n = f[3]; z = f[2]; v = f[1]; cy = f[0];
      case (c[3:1])
         3'd0: base = 1'b1;
         3'd1: base = !cy && !z;
         3'd2: base = !cy;
         3'd3: base = !z;
         3'd4: base = !v;
         3'd5: base = !n;
         3'd6: base = (n == v);
         default: base = !z && (n == v);
      endcase
      return base ^ c[0];
   endfunction

   function automatic exp_t model(int p, logic r, logic [15:0] i, logic [3:0] f);
      exp_t e;
      e = '0;
      e.st = 3'(1 << p);
      if (r) return e;
      if (p == 0) begin
         e.fe = 1'b1; e.mr = 1'b1;
      end else if (p == 1) begin
         if (i[15:13] == 3'd7) begin
            e.a = 3'd7; e.d = 3'd7; e.eo = 1'b1; e.it = 1'b1;
            e.rw = cond_taken(i[11:8], f);
         end else if (i[15:13] == 3'd6) begin
            e.eo = i[12]; e.a = i[7:5]; e.b = i[4:2];
         end else begin
            e.af = i[15:13]; e.eo = i[12];
            e.d = i[10:8]; e.a = i[7:5]; e.b = i[4:2];
            e.so = i[12] ? 2'b00 : i[1:0];
            e.rw = 1'b1; e.cc = i[11];
         end
      end else begin
         e.as = 1'b1; e.d = i[10:8];
         if (i[11]) e.mw = 1'b1;
         else begin e.mr = 1'b1; e.rw = 1'b1; end
      end
      return e;
   endfunction

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(logic r, logic [15:0] i, logic [3:0] f, logic rdy, string ctx);
      exp_t e;
      logic eff_rdy;
      rst = r; ir = i; flags = f; mem_ready = rdy;
`ifdef STUMP_MEM_WAIT_EN
      eff_rdy = rdy;
`else
      eff_rdy = 1'b1;
`endif
      #1;
      e = model(ph, r, i, f);
      chk({ctx, ".state"},     16'(state),     16'(e.st));
      chk({ctx, ".fetch_en"},  16'(fetch_en),  16'(e.fe));
      chk({ctx, ".reg_write"}, 16'(reg_write), 16'(e.rw));
      chk({ctx, ".cc_en"},     16'(cc_en),     16'(e.cc));
      chk({ctx, ".mem_ren"},   16'(mem_ren),   16'(e.mr));
      chk({ctx, ".mem_wen"},   16'(mem_wen),   16'(e.mw));
      chk({ctx, ".alu_func"},  16'(alu_func),  16'(e.af));
      chk({ctx, ".shift_op"},  16'(shift_op),  16'(e.so));
      chk({ctx, ".dest"},      16'(dest),      16'(e.d));
      chk({ctx, ".src_a"},     16'(src_a),     16'(e.a));
      chk({ctx, ".src_b"},     16'(src_b),     16'(e.b));
      chk({ctx, ".ext_op"},    16'(ext_op),    16'(e.eo));
      chk({ctx, ".imm_type"},  16'(imm_type),  16'(e.it));
      chk({ctx, ".addr_sel"},  16'(addr_sel),  16'(e.as));
      chk({ctx, ".rw_excl"},   16'(mem_ren & mem_wen), 16'(0));
      @(posedge clk);
      if (r)           ph = 0;
      else if (ph == 0) ph = eff_rdy ? 1 : 0;
      else if (ph == 1) ph = (i[15:13] == 3'd6) ? 2 : 0;
      else              ph = eff_rdy ? 0 : 2;
      #1;
   endtask

   initial begin
      // first reset edge establishes a known state
      @(posedge clk);
      #1;
      ph = 0;
      step(1'b1, 16'h0A2C, 4'h0, 1'b1, "reset");

      step(1'b0, 16'h0A2C, 4'h0, 1'b1, "alu_fetch");
      step(1'b0, 16'h0A2C, 4'h0, 1'b1, "alu_exec");
      step(1'b0, 16'hD4A3, 4'h0, 1'b1, "ld_fetch");
      step(1'b0, 16'hD4A3, 4'h0, 1'b1, "ld_exec");
      step(1'b0, 16'hD4A3, 4'h0, 1'b1, "ld_mem");
      step(1'b0, 16'hDCA3, 4'h0, 1'b1, "st_fetch");
      step(1'b0, 16'hDCA3, 4'h0, 1'b1, "st_exec");
      step(1'b0, 16'hDCA3, 4'h0, 1'b1, "st_mem");
      step(1'b0, 16'hE705, 4'h4, 1'b1, "beq_t_fetch");
      step(1'b0, 16'hE705, 4'h4, 1'b1, "beq_t_exec");
      step(1'b0, 16'hE705, 4'h0, 1'b1, "beq_n_fetch");
      step(1'b0, 16'hE705, 4'h0, 1'b1, "beq_n_exec");
      step(1'b0, 16'hEC05, 4'hA, 1'b1, "bge_fetch");
      step(1'b0, 16'hEC05, 4'hA, 1'b1, "bge_exec");
`ifdef STUMP_MEM_WAIT_EN
      step(1'b0, 16'hD4A3, 4'h0, 1'b1, "wait_fetch");
      step(1'b0, 16'hD4A3, 4'h0, 1'b1, "wait_exec");
      for (int k = 0; k < 3; k++)
         step(1'b0, 16'hD4A3, 4'h0, 1'b0, "wait_hold");
      step(1'b0, 16'hD4A3, 4'h0, 1'b1, "wait_go");
`endif
      step(1'b0, 16'hDCA3, 4'h0, 1'b1, "abort_fetch");
      step(1'b0, 16'hDCA3, 4'h0, 1'b1, "abort_exec");
      step(1'b1, 16'hDCA3, 4'h0, 1'b1, "abort_mem");
      step(1'b0, 16'hDCA3, 4'h0, 1'b1, "abort_after");

      for (int k = 0; k < 400; k++) begin
         logic        r, rdy;
         logic [15:0] i;
         logic [3:0]  f;
         r   = ($urandom_range(0, 19) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         i   = 16'($urandom);
         f   = 4'($urandom);
         step(r, i, f, rdy, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stump_controller.md
STUMP_CONTROLLER -- requirements
Module: stump_controller

Interface
REQ-001 SHALL have parameter PC_REG, default 3'd7, register index used as the program counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ir  input  16  current instruction register contents.
REQ-005 SHALL have port flags  input  4  current condition-code register {N,Z,V,C}.
REQ-006 SHALL have port mem_ready  input  1  memory completion strobe; present only when STUMP_MEM_WAIT_EN is defined.
REQ-007 SHALL have port state  output  3  one-hot state {MEMORY,EXECUTE,FETCH}.
REQ-008 SHALL have ports fetch_en, reg_write, cc_en, mem_ren, mem_wen  output  1 each  strobes for IR load/PC increment, register write, flag write, memory read and memory write.
REQ-009 SHALL have ports alu_func (output, 3 bits) and shift_op (output, 2 bits), the ALU function code and shifter operation.
REQ-010 SHALL have ports dest, src_a and src_b  output  3 each  register indices.
REQ-011 SHALL have ports ext_op, imm_type and addr_sel  output  1 each  operand B from immediate, immediate width (0 = 5-bit sign-extended, 1 = 8-bit branch offset) and address source (0 = PC, 1 = ALU result).

Function
REQ-012 SHALL hold a registered state with values FETCH = 001, EXECUTE = 010 and MEMORY = 100; all other outputs SHALL decode combinationally from state, ir and flags.
REQ-013 FETCH SHALL assert fetch_en and mem_ren with addr_sel = 0, and SHALL then go to EXECUTE.
REQ-014 EXECUTE with ir[15:13] not equal to 11x SHALL drive the following, then go to FETCH:
- alu_func = ir[15:13], ext_op = ir[12];
- dest = ir[10:8], src_a = ir[7:5], src_b = ir[4:2];
- shift_op = ir[1:0] when ir[12] = 0, else 00;
- reg_write = 1, cc_en = ir[11].
REQ-015 EXECUTE with opcode 110 (LD/ST) SHALL drive the following, then go to MEMORY:
- alu_func = 000 (ADD), which computes the address;
- ext_op = ir[12], src_a = ir[7:5], src_b = ir[4:2];
- reg_write = 0, cc_en = 0.
REQ-016 EXECUTE with opcode 111 (Bcc) SHALL drive the following, then go to FETCH:
- alu_func = 000, src_a = PC_REG, dest = PC_REG;
- ext_op = 1, imm_type = 1;
- reg_write = condition result for ir[11:8], cc_en = 0.
REQ-017 Conditions SHALL be evaluated as:
- 0 always; 1 never;
- 2 !C&!Z; 3 C|Z; 4 !C; 5 C; 6 !Z; 7 Z;
- 8 !V; 9 V; A !N; B N;
- C N==V; D N!=V; E !Z&(N==V); F Z|(N!=V).
REQ-018 MEMORY SHALL drive addr_sel = 1 and dest = ir[10:8], then go to FETCH.
- Load (ir[11] = 0): mem_ren = 1, reg_write = 1.
- Store (ir[11] = 1): mem_wen = 1, reg_write = 0; dest then selects the store-data register.
REQ-019 Any output not specified for the current state SHALL be 0.
REQ-020 Latency SHALL be 2 cycles for ALU and Bcc instructions and 3 cycles for LD/ST.
REQ-021 mem_ren and mem_wen SHALL never both be 1.

Reset
REQ-022 rst = 1 at a rising edge SHALL load state = FETCH from any state, including mid-instruction or mid-wait.
REQ-023 While rst = 1, fetch_en, reg_write, cc_en, mem_ren and mem_wen SHALL be forced to 0 and the other outputs SHALL be 0.

Configuration
REQ-024 With STUMP_MEM_WAIT_EN defined, FETCH and MEMORY SHALL hold state, with all outputs stable, while mem_ready = 0, and SHALL advance on the edge where mem_ready = 1.
REQ-025 Without STUMP_MEM_WAIT_EN, the mem_ready port SHALL be absent and FETCH and MEMORY SHALL last exactly one cycle.

Structure
REQ-026 A shared package stump_ctrl_pkg SHALL hold the state encodings, opcode constants (ADD through Bcc), the 16 condition codes and the flag bit indices N = 3, Z = 2, V = 1, C = 0.
REQ-027 A combinational sub-module stump_cond_eval (inputs cond[3:0] and flags[3:0], output taken) SHALL implement REQ-017.

Verification
REQ-028 Reset: rst = 1 for 2 cycles -> state = 001 and all strobes 0; after release with ir = 0x0A2C, state sequence is 001, 010, 001.
REQ-029 ALU: ir = 0x0A2C in EXECUTE -> alu_func = 000, dest = 2, src_a = 1, src_b = 3, shift_op = 00, reg_write = 1, cc_en = 1.
REQ-030 LD/ST: ir = 0xD4A3 -> states 001, 010, 100; in MEMORY mem_ren = 1, addr_sel = 1, reg_write = 1, dest = 4; ir = 0xDCA3 -> mem_wen = 1, reg_write = 0.
REQ-031 Branch: ir = 0xE705 (BEQ) with flags = 0100 -> reg_write = 1, dest = 7, imm_type = 1; flags = 0000 -> reg_write = 0; BGE (ir = 0xEC05) with flags = 1010 -> taken.
REQ-032 Wait (STUMP_MEM_WAIT_EN): LD with mem_ready = 0 for 3 cycles in MEMORY -> state holds 100 with mem_ren = 1; mem_ready = 1 -> state = 001 on the next edge.
REQ-033 Abort: rst = 1 during MEMORY of a store -> mem_wen = 0 in that cycle and state = 001 on the next edge.
